// File: rtl/user_event_mux_fifo.sv
// ---------------------------------------------------------------------------
// user_event_pkg / user_event_mux_fifo
//
// Purpose
//   Gathers user events (keyboard, buttons, demo player) from CH_CNT
//   independent valid/ready sources. A round-robin arbiter grants at most
//   one source per cycle. Accepted events go into a DEPTH-entry FIFO whose
//   oldest entry is offered to the game logic. A full FIFO either
//   back-pressures the sources or silently discards events while counting
//   them. A flush empties the FIFO when a new game starts.
//
// Ports
//   clk_i               system clock
//   rst_i               synchronous, active-high reset
//   src_event_i         per-source event, channel i at [i*EV_W +: EV_W]
//   src_valid_i         per-source event valid
//   src_ready_o         per-source accept, one-hot or zero (combinational)
//   flush_i             discard every buffered event
//   user_event_o        head-of-FIFO event, holds its last value when empty
//   user_event_ready_o  FIFO holds at least one event
//   user_event_rd_req_i pop the head event
//   used_words_o        number of events held
//   drop_cnt_o          saturating count of discarded events
// ---------------------------------------------------------------------------
package user_event_pkg;
  typedef enum logic [2:0] {
    EV_NONE     = 3'd0,
    EV_LEFT     = 3'd1,
    EV_RIGHT    = 3'd2,
    EV_ROTATE   = 3'd3,
    EV_DOWN     = 3'd4,
    EV_PAUSE    = 3'd5,
    EV_NEW_GAME = 3'd6
  } user_event_t;
endpackage

module user_event_mux_fifo
  import user_event_pkg::*;
#(
  parameter int CH_CNT       = 2,
  parameter int DEPTH        = 8,
  parameter int EV_W         = $bits(user_event_t),
  parameter int DROP_ON_FULL = 0,
  parameter int DROP_CNT_W   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [CH_CNT*EV_W-1:0]   src_event_i,
  input  logic [CH_CNT-1:0]        src_valid_i,
  output logic [CH_CNT-1:0]        src_ready_o,
  input  logic                     flush_i,
  output logic [EV_W-1:0]          user_event_o,
  output logic                     user_event_ready_o,
  input  logic                     user_event_rd_req_i,
  output logic [$clog2(DEPTH):0]   used_words_o,
  output logic [DROP_CNT_W-1:0]    drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (CH_CNT > 1) ? $clog2(CH_CNT) : 1;

  logic [EV_W-1:0]       mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         used;
  logic [GW-1:0]         rr_start;
  logic [EV_W-1:0]       head_q;
  logic [DROP_CNT_W-1:0] drop_cnt;

  logic [2*CH_CNT-1:0]   valid_dbl;
  logic [CH_CNT-1:0]     valid_rot;
  logic                  grant_valid;
  logic [GW-1:0]         grant_idx;
  logic [EV_W-1:0]       grant_event;

  logic full;
  logic empty;
  logic accept_en;
  logic xfer;
  logic push;
  logic drop;
  logic pop;

  // Rotate the valid vector so that bit k is the channel k places after the
  // search start; the first set bit of the rotated vector is the winner.
  assign valid_dbl = {src_valid_i, src_valid_i};
  assign valid_rot = CH_CNT'(valid_dbl >> rr_start);

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < CH_CNT; k++) begin
      if (!grant_valid && valid_rot[k]) begin
        grant_valid = 1'b1;
        grant_idx   = GW'((int'(rr_start) + k) % CH_CNT);
      end
    end
  end

  assign grant_event = src_event_i[grant_idx*EV_W +: EV_W];

  assign full  = (used == CW'(DEPTH));
  assign empty = (used == '0);

  // In back-pressure mode a full FIFO grants nobody, even if the head is
  // popped this cycle; the freed slot becomes usable one cycle later.
  assign accept_en = !rst_i && !flush_i && (!full || (DROP_ON_FULL != 0));
  assign xfer      = accept_en && grant_valid;
  assign push      = xfer && !full;
  assign drop      = xfer && full;
  assign pop       = user_event_rd_req_i && !empty && !flush_i;

  always_comb begin
    src_ready_o = '0;
    if (xfer) begin
      src_ready_o[grant_idx] = 1'b1;
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= grant_event;
    end
  end

  // Pointers, fill level, arbitration pointer, drop counter and the
  // registered head. The head register is loaded with the entry that will
  // be oldest after this edge, so it only changes when the head changes and
  // keeps the last popped value once the FIFO runs dry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      used     <= '0;
      rr_start <= '0;
      head_q   <= '0;
      drop_cnt <= '0;
    end else begin
      if (xfer) begin
        rr_start <= GW'((int'(grant_idx) + 1) % CH_CNT);
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        used   <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   used <= used + 1'b1;
          2'b01:   used <= used - 1'b1;
          default: used <= used;
        endcase
        if (pop) begin
          if (used > CW'(1)) begin
            head_q <= mem[rd_ptr + 1'b1];
          end else if (push) begin
            head_q <= grant_event;
          end
        end else if (push && empty) begin
          head_q <= grant_event;
        end
      end
    end
  end

  assign user_event_o       = head_q;
  assign user_event_ready_o = !empty;
  assign used_words_o       = used;
  assign drop_cnt_o         = drop_cnt;

endmodule

// File: tb/tb_user_event_mux_fifo.sv
// ---------------------------------------------------------------------------
// tb_user_event_mux_fifo
//
// Two instances share clock and reset: dut 0 back-pressures when full,
// dut 1 discards when full with a 2-bit drop counter. Source drivers feed
// per-channel queues through valid/ready; expected outputs are queued when
// stimulus is issued and a monitor compares them on every pop.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_user_event_mux_fifo;
  import user_event_pkg::*;

  localparam int CH    = 2;
  localparam int DEPTH = 8;
  localparam int EW    = 8;
  localparam int UW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [CH*EW-1:0]  src_event [2];
  logic [CH-1:0]     src_valid [2];
  logic [CH-1:0]     src_ready [2];
  logic              flush     [2];
  logic [EW-1:0]     ev_out    [2];
  logic              ev_ready  [2];
  logic              rd_req    [2];
  logic [UW-1:0]     used      [2];
  logic [7:0]        drop0;
  logic [1:0]        drop1;

  logic [EW-1:0]     src_q     [2*CH][$];
  logic [EW-1:0]     exp_q     [2][$];
  int                exp_grant [2][$];
  logic [CH-1:0]     took      [2];

  int vectors     = 0;
  int miscompares = 0;

  user_event_mux_fifo #(
    .CH_CNT(CH), .DEPTH(DEPTH), .EV_W(EW), .DROP_ON_FULL(0), .DROP_CNT_W(8)
  ) dut_bp (
    .clk_i(clk), .rst_i(rst),
    .src_event_i(src_event[0]), .src_valid_i(src_valid[0]), .src_ready_o(src_ready[0]),
    .flush_i(flush[0]),
    .user_event_o(ev_out[0]), .user_event_ready_o(ev_ready[0]),
    .user_event_rd_req_i(rd_req[0]),
    .used_words_o(used[0]), .drop_cnt_o(drop0)
  );

  user_event_mux_fifo #(
    .CH_CNT(CH), .DEPTH(DEPTH), .EV_W(EW), .DROP_ON_FULL(1), .DROP_CNT_W(2)
  ) dut_dr (
    .clk_i(clk), .rst_i(rst),
    .src_event_i(src_event[1]), .src_valid_i(src_valid[1]), .src_ready_o(src_ready[1]),
    .flush_i(flush[1]),
    .user_event_o(ev_out[1]), .user_event_ready_o(ev_ready[1]),
    .user_event_rd_req_i(rd_req[1]),
    .used_words_o(used[1]), .drop_cnt_o(drop1)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Queue one event on a source; optionally record that it must come out.
  task automatic applyStimulus(input int d, input int ch, input logic [EW-1:0] ev,
                               input bit expect_out);
    src_q[d*CH+ch].push_back(ev);
    if (expect_out) exp_q[d].push_back(ev);
  endtask

  task automatic waitDrain(input int d, input int budget, input string name);
    int n = 0;
    while ((exp_q[d].size() != 0 || src_q[d*CH].size() != 0 ||
            src_q[d*CH+1].size() != 0 || src_valid[d] != '0) && n < budget) begin
      tick(1);
      n++;
    end
    if (exp_q[d].size() != 0 || src_q[d*CH].size() != 0 ||
        src_q[d*CH+1].size() != 0 || src_valid[d] != '0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: not drained after %0d cycles, %0d outputs outstanding",
               name, budget, exp_q[d].size());
    end
  endtask

  // Source drivers (posedge+1) and monitors (negedge) per instance.
  for (genvar d = 0; d < 2; d++) begin : g_chk
    always begin
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++) begin
        if (src_valid[d][c] && took[d][c]) src_valid[d][c] = 1'b0;
        if (!src_valid[d][c] && src_q[d*CH+c].size() > 0) begin
          src_event[d][c*EW +: EW] = src_q[d*CH+c].pop_front();
          src_valid[d][c] = 1'b1;
        end
      end
    end

    always @(negedge clk) begin
      took[d] = src_valid[d] & src_ready[d];
      for (int c = 0; c < CH; c++) begin
        if (took[d][c] && exp_grant[d].size() > 0)
          checkOutput($sformatf("dut%0d grant", d), c, exp_grant[d].pop_front());
      end
      if (rd_req[d] && ev_ready[d] && !flush[d] && !rst) begin
        if (exp_q[d].size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL dut%0d pop: got 0x%0h, expected no output", d, ev_out[d]);
        end else begin
          checkOutput($sformatf("dut%0d pop", d), ev_out[d], exp_q[d].pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      flush[d]     = 1'b0;
      rd_req[d]    = 1'b0;
      src_valid[d] = '1;
      src_event[d] = '0;
      took[d]      = '0;
    end

    // Reset held two cycles with every source requesting.
    repeat (2) @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("dut%0d reset src_ready", d), src_ready[d], 0);
      checkOutput($sformatf("dut%0d reset ready", d), ev_ready[d], 0);
      checkOutput($sformatf("dut%0d reset used", d), used[d], 0);
      checkOutput($sformatf("dut%0d reset event", d), ev_out[d], 0);
      src_valid[d] = '0;
    end
    checkOutput("dut0 reset drop", drop0, 0);
    checkOutput("dut1 reset drop", drop1, 0);
    tick(1);
    rst = 1'b0;
    tick(1);

    // Round-robin: both sources always valid, grants alternate from ch 0.
    $display("[TB] round-robin");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, {5'(i), EV_LEFT}, 1'b1);
      applyStimulus(0, 1, {5'(i), EV_ROTATE}, 1'b1);
      exp_grant[0].push_back(0);
      exp_grant[0].push_back(1);
    end
    rd_req[0] = 1'b1;
    waitDrain(0, 40, "rr drain");
    rd_req[0] = 1'b0;
    checkOutput("rr grants outstanding", exp_grant[0].size(), 0);
    checkOutput("rr used", used[0], 0);

    // Fill with back-pressure: 8 held, 9th stalled, rest accepted later.
    $display("[TB] fill");
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, {5'(i), EV_RIGHT}, 1'b1);
    tick(14);
    checkOutput("fill used", used[0], 8);
    checkOutput("fill src_ready", src_ready[0], 0);
    checkOutput("fill src_valid held", src_valid[0], 2'b01);
    checkOutput("fill ready", ev_ready[0], 1);
    rd_req[0] = 1'b1;
    waitDrain(0, 40, "fill drain");
    rd_req[0] = 1'b0;
    checkOutput("fill used after drain", used[0], 0);

    // Drop mode: overflow counted, then saturates at 3.
    $display("[TB] drop");
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, {5'(i), EV_RIGHT}, i < 8);
    tick(14);
    checkOutput("drop used", used[1], 8);
    checkOutput("drop count", drop1, 2);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, {5'(20 + i), EV_DOWN}, 1'b0);
    tick(8);
    checkOutput("drop count saturated", drop1, 3);
    checkOutput("drop used still full", used[1], 8);
    rd_req[1] = 1'b1;
    waitDrain(1, 40, "drop drain");
    rd_req[1] = 1'b0;
    checkOutput("drop used after drain", used[1], 0);
    checkOutput("drop count kept", drop1, 3);

    // Single-event handshake latency and empty-read protection.
    $display("[TB] handshake");
    applyStimulus(0, 1, {5'd0, EV_NEW_GAME}, 1'b1);
    tick(1);
    checkOutput("hs ready before push", ev_ready[0], 0);
    checkOutput("hs src_ready", src_ready[0], 2'b10);
    tick(1);
    checkOutput("hs ready after push", ev_ready[0], 1);
    checkOutput("hs used", used[0], 1);
    rd_req[0] = 1'b1;
    tick(1);
    checkOutput("hs ready after pop", ev_ready[0], 0);
    checkOutput("hs used after pop", used[0], 0);
    tick(1);
    checkOutput("hs used empty read", used[0], 0);
    checkOutput("hs event held", ev_out[0], {5'd0, EV_NEW_GAME});
    rd_req[0] = 1'b0;

    // Flush with a simultaneous push request and pop request.
    $display("[TB] flush");
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, {5'(i), EV_DOWN}, 1'b0);
    tick(8);
    checkOutput("flush used before", used[0], 5);
    applyStimulus(0, 1, {5'd31, EV_PAUSE}, 1'b1);
    tick(1);
    flush[0]  = 1'b1;
    rd_req[0] = 1'b1;
    #1;
    checkOutput("flush src_ready", src_ready[0], 0);
    tick(1);
    flush[0]  = 1'b0;
    rd_req[0] = 1'b0;
    checkOutput("flush used", used[0], 0);
    checkOutput("flush ready", ev_ready[0], 0);
    checkOutput("flush drop", drop0, 0);
    rd_req[0] = 1'b1;
    waitDrain(0, 20, "flush drain");
    rd_req[0] = 1'b0;
    checkOutput("flush used after drain", used[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
